snake_body_engine: RTL



---
 rtl/snake_body_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/snake_body_engine.sv
`default_nettype none
// snake_body_engine -- circular-buffer snake body with per-tick erase-tail / draw-head pixel commands.
// Revision: 1.0
module snake_body_engine #(
  parameter int         X_W          = 8,
  parameter int         Y_W          = 7,
  parameter int         MAX_LEN      = 128,
  parameter int         GRID_W       = 160,
  parameter int         GRID_H       = 120,
  parameter int         START_X      = 60,
  parameter int         START_Y      = 40,
  parameter bit         WRAP         = 1'b0,
  parameter logic [2:0] SNAKE_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] DEAD_COLOUR  = 3'b100,
  localparam int        PTR_W        = $clog2(MAX_LEN),
  localparam int        LEN_W        = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       direction,
  input  logic             grow,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [2:0]       colour,
  output logic             plot,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             game_over
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_CALC  = 3'd2,
    S_SCAN  = 3'd3,
    S_ERASE = 3'd4,
    S_DRAW  = 3'd5,
    S_DEAD  = 3'd6
  } state_t;

  state_t r_state, w_state_n;

  logic [X_W+Y_W-1:0] r_body [MAX_LEN];
  logic [PTR_W-1:0]   r_head_ptr, r_scan_cnt, r_scan_last, w_scan_idx, w_tail_idx;
  logic [1:0]         r_dir;
  logic               r_grow_pending, r_grow_now, w_grow_now, w_wall, w_hit;
  logic [X_W-1:0]     r_nx, w_nx;
  logic [Y_W-1:0]     r_ny, w_ny;
  logic [LEN_W-1:0]   w_scan_len;

  assign w_scan_idx = r_head_ptr - r_scan_cnt;
  assign w_tail_idx = r_head_ptr - PTR_W'(length) + PTR_W'(1);
  assign w_hit      = (r_body[w_scan_idx] == {r_nx, r_ny});
  assign w_grow_now = r_grow_pending && (length < LEN_W'(MAX_LEN));
  // The vacating tail is left out of the scan unless the body is growing.
  assign w_scan_len = w_grow_now ? length : length - LEN_W'(1);

  // Next head cell and wall detection (UP decreases y, screen orientation).
  always_comb begin
    w_nx   = head_x;
    w_ny   = head_y;
    w_wall = 1'b0;
    case (r_dir)
      2'b00: if (head_x == '0) begin
               if (WRAP) w_nx = X_W'(GRID_W - 1); else w_wall = 1'b1;
             end else w_nx = head_x - X_W'(1);
      2'b01: if (head_y == '0) begin
               if (WRAP) w_ny = Y_W'(GRID_H - 1); else w_wall = 1'b1;
             end else w_ny = head_y - Y_W'(1);
      2'b10: if (head_y == Y_W'(GRID_H - 1)) begin
               if (WRAP) w_ny = '0; else w_wall = 1'b1;
             end else w_ny = head_y + Y_W'(1);
      default: if (head_x == X_W'(GRID_W - 1)) begin
               if (WRAP) w_nx = '0; else w_wall = 1'b1;
             end else w_nx = head_x + X_W'(1);
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_INIT:  w_state_n = S_IDLE;
      S_IDLE:  if (tick) w_state_n = S_CALC;
      S_CALC:  if (w_wall)                 w_state_n = S_DEAD;
               else if (w_scan_len == '0)  w_state_n = S_ERASE;
               else                        w_state_n = S_SCAN;
      S_SCAN:  if (w_hit)                          w_state_n = S_DEAD;
               else if (r_scan_cnt == r_scan_last) w_state_n = r_grow_now ? S_DRAW : S_ERASE;
      S_ERASE: w_state_n = S_DRAW;
      S_DRAW:  w_state_n = S_IDLE;
      S_DEAD:  w_state_n = S_DEAD;
      default: w_state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_n;
  end

  // Body storage; not reset, INIT seeds index 0 before any read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_INIT)
        r_body[0] <= {X_W'(START_X), Y_W'(START_Y)};
      else if (w_state_n == S_DRAW)
        r_body[r_head_ptr + PTR_W'(1)] <= {r_nx, r_ny};
    end
  end

  // Pixel commands are registered on the edge that enters the commanding state.
  always_ff @(posedge clk) begin
    if (reset) begin
      plot           <= 1'b0;
      x              <= '0;
      y              <= '0;
      colour         <= '0;
      head_x         <= X_W'(START_X);
      head_y         <= Y_W'(START_Y);
      length         <= LEN_W'(1);
      game_over      <= 1'b0;
      busy           <= 1'b1;
      r_grow_pending <= 1'b0;
      r_head_ptr     <= '0;
      r_dir          <= 2'b00;
      r_grow_now     <= 1'b0;
      r_scan_cnt     <= '0;
      r_scan_last    <= '0;
      r_nx           <= '0;
      r_ny           <= '0;
    end else begin
      plot <= 1'b0;
      busy <= (w_state_n != S_IDLE) && (w_state_n != S_DEAD);
      if (grow && r_state != S_DEAD) r_grow_pending <= 1'b1;

      case (r_state)
        S_INIT: begin
          plot   <= 1'b1;
          x      <= X_W'(START_X);
          y      <= Y_W'(START_Y);
          colour <= SNAKE_COLOUR;
        end
        S_IDLE: if (tick) r_dir <= direction;
        S_CALC: begin
          r_grow_pending <= grow;
          r_grow_now     <= w_grow_now;
          r_nx           <= w_nx;
          r_ny           <= w_ny;
          r_scan_cnt     <= '0;
          r_scan_last    <= PTR_W'(w_scan_len - LEN_W'(1));
        end
        S_SCAN: r_scan_cnt <= r_scan_cnt + PTR_W'(1);
        default: ;
      endcase

      if (w_state_n == S_DEAD && r_state != S_DEAD) begin
        plot      <= 1'b1;
        x         <= head_x;
        y         <= head_y;
        colour    <= DEAD_COLOUR;
        game_over <= 1'b1;
      end
      if (w_state_n == S_ERASE) begin
        plot   <= 1'b1;
        {x, y} <= r_body[w_tail_idx];
        colour <= BG_COLOUR;
      end
      if (w_state_n == S_DRAW) begin
        plot       <= 1'b1;
        x          <= r_nx;
        y          <= r_ny;
        colour     <= SNAKE_COLOUR;
        head_x     <= r_nx;
        head_y     <= r_ny;
        r_head_ptr <= r_head_ptr + PTR_W'(1);
        if (r_grow_now) length <= length + LEN_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
